pid_term_sched: RTL
===================

# pid_term_sched

Sequencing controller for the PID error path. It accepts saturated heading-error samples and runs one shared signed multiplier over the P and D products with a four-state FSM. It also maintains the integrator and D-history pipeline, then emits saturated P, I, D and PID terms with a one-cycle valid pulse. It sits between the error-saturation stage and the motor-drive mixer.

## Interface
- P_COEFF, 6'h10, signed proportional coefficient
- D_COEFF, 5'h07, signed derivative coefficient, sign-extended to 6 bits at the multiplier
- D_DEPTH, 3, number of accepted samples between current and "previous" error
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- err_sat  in  10  signed saturated error sample
- err_vld  in  1  sample strobe, one cycle
- clr_ovr  in  1  clears overrun
- busy  out  1  high in MUL_P, MUL_D, SUM
- pid_vld  out  1  one-cycle pulse; all term outputs updated at the same edge
- P_term  out  14  signed
- I_term  out  12  signed
- D_term  out  13  signed
- PID  out  14  signed, saturated sum
- overrun  out  1  sticky: sample dropped while busy

## Operation
- FSM states: IDLE, MUL_P, MUL_D, SUM.
  - IDLE → MUL_P on err_vld.
  - MUL_P → MUL_D, MUL_D → SUM, SUM → IDLE unconditionally.
- Acceptance happens at the IDLE edge with err_vld high:
  - err_sat latched into err_q.
  - History shift register (D_DEPTH entries, 10-bit) shifts err_sat in; prev_err is the oldest entry before the shift.
  - Integrator (16-bit signed) adds sign-extended err_sat, saturating to 0x7FFF / 0x8000.
- D_diff = err_q − prev_err, computed in 11 bits, saturated to 8-bit signed [−128, 127].
- Shared multiplier: one signed 10×6 instance.
  - MUL_P: err_q × P_COEFF.
  - MUL_D: sign-extended D_diff_sat × D_COEFF.
  - Product registered at the end of each state.
- P_term = P product saturated to 14 bits [−8192, 8191].
- D_term = D product, 13 bits; it always fits.
- I_term = integrator[15:4].
- PID = P_term + sext(I_term) + sext(D_term), computed in 16 bits and saturated to 14 bits. Registered in SUM.
- err_vld while busy:
  - Sample dropped; no history or integrator update.
  - overrun set.
- clr_ovr clears overrun. If a drop and clr_ovr occur in the same cycle, set wins.
- Term outputs hold their last values between pid_vld pulses.

## Timing
- Reset (synchronous, any state):
  - state = IDLE.
  - All outputs = 0, including busy, pid_vld and overrun.
  - History, integrator, err_q and product registers = 0.
  - Partial results are discarded and no pid_vld is produced.
- Edge numbering for one accepted sample:
  - Edge 0: capture.
  - Edge 1: P product registered.
  - Edge 2: D product registered.
  - Edge 3: all term outputs updated, pid_vld = 1 for the following cycle.
- busy is high from edge 0 to edge 3.
- Latency is 3 cycles from capture.
- Max throughput is one sample per 4 cycles. err_vld in the cycle pid_vld is high (state IDLE) is accepted.
- err_vld during reset is ignored.

## Test plan
- Basic path: reset, then err_sat=64 with err_vld → 3 cycles later pid_vld=1 with:
  - P_term=1024
  - I_term=4
  - D_term=448
  - PID=1476
- D saturation:
  - From reset, err_sat=511 → D_term=889 (diff clamped to 127).
  - After a fresh reset, err_sat=−512 → D_term=−896 (diff clamped to −128).
- History depth: accept 10, 20, 30, 40 → 4th result D_term=210 (40−10=30, ×7).
- Saturation under sustained error: accept err_sat=511 sixty-five times → integrator clamps at 0x7FFF. On the 65th result:
  - I_term=2047
  - P_term=8176
  - PID=8191
- Overrun: pulse err_vld one cycle after an accepted sample →
  - Sample ignored (history and integrator unchanged).
  - overrun=1 and stays 1.
  - clr_ovr pulse → overrun=0.
- Reset mid-operation: assert rst during MUL_D →
  - No pid_vld.
  - All outputs 0 the next cycle.
  - Next sample err_sat=8 gives D_term=56 and I_term=0.

Source files
------------

// File: rtl/pid_term_sched_if.sv
// -----------------------------------------------------------------------------
// pid_term_sched_if
// Bundle between the error-saturation stage and the PID term sequencer.
//   err_sat  10  signed saturated heading-error sample   (master -> slave)
//   err_vld   1  one-cycle sample strobe                  (master -> slave)
//   clr_ovr   1  clears the sticky overrun flag           (master -> slave)
//   busy      1  sequencer is working on a sample         (slave -> master)
//   pid_vld   1  one-cycle pulse, term outputs refreshed  (slave -> master)
//   P_term   14  signed saturated proportional term       (slave -> master)
//   I_term   12  signed integral term                     (slave -> master)
//   D_term   13  signed derivative term                   (slave -> master)
//   PID      14  signed saturated sum of the three terms  (slave -> master)
//   overrun   1  sticky: a sample was dropped while busy  (slave -> master)
// -----------------------------------------------------------------------------
interface pid_term_sched_if;
  logic signed [9:0]  err_sat;
  logic               err_vld;
  logic               clr_ovr;
  logic               busy;
  logic               pid_vld;
  logic signed [13:0] P_term;
  logic signed [11:0] I_term;
  logic signed [12:0] D_term;
  logic signed [13:0] PID;
  logic               overrun;

  modport master (
    output err_sat, err_vld, clr_ovr,
    input  busy, pid_vld, P_term, I_term, D_term, PID, overrun
  );

  modport slave (
    input  err_sat, err_vld, clr_ovr,
    output busy, pid_vld, P_term, I_term, D_term, PID, overrun
  );
endinterface

// File: rtl/pid_term_sched.sv
// -----------------------------------------------------------------------------
// pid_term_sched
// Sequences one shared signed 10x6 multiplier over the P and D products of a
// saturated heading-error sample, keeps the integrator and derivative history,
// and emits saturated P/I/D/PID terms with a one-cycle valid pulse.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   bus  slave side of pid_term_sched_if (sample in, terms/status out)
// -----------------------------------------------------------------------------
module pid_term_sched #(
  parameter logic signed [5:0] P_COEFF = 6'sh10,
  parameter logic signed [4:0] D_COEFF = 5'sh07,
  parameter int                D_DEPTH = 3
) (
  input logic             clk,
  input logic             rst,
  pid_term_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_P = 2'd1,
    MUL_D = 2'd2,
    SUM   = 2'd3
  } state_t;

  // Clamp an 11-bit difference to the 8-bit signed range.
  function automatic logic signed [7:0] sat8(input logic signed [10:0] v);
    if (v > 11'sd127) begin
      sat8 = 8'sh7F;
    end else if (v < -11'sd128) begin
      sat8 = 8'sh80;
    end else begin
      sat8 = v[7:0];
    end
  endfunction

  // Clamp a 16-bit value to the 14-bit signed range.
  function automatic logic signed [13:0] sat14(input logic signed [15:0] v);
    if (v > 16'sd8191) begin
      sat14 = 14'sh1FFF;
    end else if (v < -16'sd8192) begin
      sat14 = 14'sh2000;
    end else begin
      sat14 = v[13:0];
    end
  endfunction

  // Clamp a 17-bit integrator sum to the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767) begin
      sat16 = 16'sh7FFF;
    end else if (v < -17'sd32768) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic               drop_s;
  logic               busy_nxt_s;
  logic               sel_d_s;
  logic               ld_p_s;
  logic               ld_d_s;
  logic               ld_out_s;

  logic signed [9:0]  err_q_r;
  logic signed [9:0]  prev_r;
  logic signed [9:0]  hist_r [D_DEPTH];
  logic signed [15:0] integ_r;
  logic signed [15:0] prod_p_r;
  logic signed [12:0] prod_d_r;

  logic signed [16:0] integ_sum_s;
  logic signed [10:0] diff_s;
  logic signed [7:0]  diff_sat_s;
  logic signed [9:0]  mul_a_s;
  logic signed [5:0]  mul_b_s;
  logic signed [15:0] mul_y_s;
  logic signed [13:0] p_sat_s;
  logic signed [11:0] i_val_s;
  logic signed [12:0] d_val_s;
  logic signed [15:0] pid_sum_s;
  logic signed [13:0] pid_sat_s;

  logic               busy_r;
  logic               pid_vld_r;
  logic               overrun_r;
  logic signed [13:0] p_term_r;
  logic signed [11:0] i_term_r;
  logic signed [12:0] d_term_r;
  logic signed [13:0] pid_r;

  // A sample is taken only in IDLE; anywhere else it is dropped.
  assign accept_s = bus.err_vld & (state_r == IDLE);
  assign drop_s   = bus.err_vld & (state_r != IDLE);

  // Next-state logic of the sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.err_vld) begin
          state_nxt_s = MUL_P;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL_P:   state_nxt_s = MUL_D;
      MUL_D:   state_nxt_s = SUM;
      SUM:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Per-state controls; busy_nxt_s is busy as it must look after this edge.
  always_comb begin
    busy_nxt_s = 1'b0;
    sel_d_s    = 1'b0;
    ld_p_s     = 1'b0;
    ld_d_s     = 1'b0;
    ld_out_s   = 1'b0;
    case (state_r)
      IDLE: begin
        busy_nxt_s = bus.err_vld;
      end
      MUL_P: begin
        busy_nxt_s = 1'b1;
        ld_p_s     = 1'b1;
      end
      MUL_D: begin
        busy_nxt_s = 1'b1;
        sel_d_s    = 1'b1;
        ld_d_s     = 1'b1;
      end
      SUM: begin
        ld_out_s   = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath: derivative difference, shared multiplier operands, term sums.
  always_comb begin
    integ_sum_s = $signed({integ_r[15], integ_r}) +
                  $signed({{7{bus.err_sat[9]}}, bus.err_sat});
    diff_s      = $signed({err_q_r[9], err_q_r}) - $signed({prev_r[9], prev_r});
    diff_sat_s  = sat8(diff_s);
    if (sel_d_s) begin
      mul_a_s = {{2{diff_sat_s[7]}}, diff_sat_s};
      mul_b_s = {D_COEFF[4], D_COEFF};
    end else begin
      mul_a_s = err_q_r;
      mul_b_s = P_COEFF;
    end
    // Low 16 bits of the extended product equal the signed product.
    mul_y_s   = $signed({{6{mul_a_s[9]}}, mul_a_s} * {{10{mul_b_s[5]}}, mul_b_s});
    p_sat_s   = sat14(prod_p_r);
    i_val_s   = integ_r[15:4];
    d_val_s   = prod_d_r;
    pid_sum_s = $signed({{2{p_sat_s[13]}}, p_sat_s}) +
                $signed({{4{i_val_s[11]}}, i_val_s}) +
                $signed({{3{d_val_s[12]}}, d_val_s});
    pid_sat_s = sat14(pid_sum_s);
  end

  // State, sample capture, history/integrator, products and term outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      pid_vld_r <= 1'b0;
      overrun_r <= 1'b0;
      err_q_r   <= 10'sd0;
      prev_r    <= 10'sd0;
      integ_r   <= 16'sd0;
      prod_p_r  <= 16'sd0;
      prod_d_r  <= 13'sd0;
      p_term_r  <= 14'sd0;
      i_term_r  <= 12'sd0;
      d_term_r  <= 13'sd0;
      pid_r     <= 14'sd0;
      for (int k = 0; k < D_DEPTH; k++) begin
        hist_r[k] <= 10'sd0;
      end
    end else begin
      state_r   <= state_nxt_s;
      busy_r    <= busy_nxt_s;
      pid_vld_r <= ld_out_s;
      if (accept_s) begin
        err_q_r   <= bus.err_sat;
        // The oldest entry is the sample D_DEPTH acceptances back.
        prev_r    <= hist_r[D_DEPTH-1];
        hist_r[0] <= bus.err_sat;
        for (int k = 1; k < D_DEPTH; k++) begin
          hist_r[k] <= hist_r[k-1];
        end
        integ_r   <= sat16(integ_sum_s);
      end
      if (ld_p_s) begin
        prod_p_r <= mul_y_s;
      end
      if (ld_d_s) begin
        // |diff| <= 128 and coeff fits 5 bits, so 13 bits always suffice.
        prod_d_r <= mul_y_s[12:0];
      end
      if (ld_out_s) begin
        p_term_r <= p_sat_s;
        i_term_r <= i_val_s;
        d_term_r <= d_val_s;
        pid_r    <= pid_sat_s;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (bus.clr_ovr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.pid_vld = pid_vld_r;
  assign bus.overrun = overrun_r;
  assign bus.P_term  = p_term_r;
  assign bus.I_term  = i_term_r;
  assign bus.D_term  = d_term_r;
  assign bus.PID     = pid_r;

endmodule
